// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a valid/ready-style instruction memory port and fills the
// IF/ID pipeline register. A one-entry hold buffer covers decode stalls, a DRAIN state finishes
// a request that a branch or halt has made stale, and HALT is left only through reset.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetchCount / stallCount outputs.
module fetch_stage #(
   parameter int unsigned ADDRESSWIDTH = 32,
   parameter int unsigned DATA = 32,
   parameter logic [ADDRESSWIDTH-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    branchTaken,
   input  logic [ADDRESSWIDTH-1:0] branchTarget,
   input  logic                    hazardDetected,
   input  logic                    haltSignal,
   output logic                    imemReq,
   output logic [ADDRESSWIDTH-1:0] imemAddr,
   input  logic                    imemValid,
   input  logic [DATA-1:0]         imemData,
   output logic [DATA-1:0]         instruction,
   output logic [ADDRESSWIDTH-1:0] pcOut,
   output logic                    instrValid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]             fetchCount,
   output logic [31:0]             stallCount,
`endif
   output logic                    halted
);

   localparam logic [ADDRESSWIDTH-1:0] PcStep    = ADDRESSWIDTH'(4);
   localparam logic [ADDRESSWIDTH-1:0] AlignMask = ~ADDRESSWIDTH'(3);

   typedef enum logic [2:0] {StIdle, StFetch, StHold, StDrain, StHalt} state_e;

   state_e                  state_q, state_d;
   logic [ADDRESSWIDTH-1:0] pc_q, pc_d;
   // Address of the stale request still being drained; pc_q already points past it.
   logic [ADDRESSWIDTH-1:0] drain_addr_q, drain_addr_d;
   logic                    halt_pend_q, halt_pend_d;
   logic [DATA-1:0]         buf_q, buf_d;
   logic [DATA-1:0]         instr_q, instr_d;
   logic [ADDRESSWIDTH-1:0] pcout_q, pcout_d;
   logic                    valid_q, valid_d;
   logic                    load_live;
   logic [ADDRESSWIDTH-1:0] branch_pc;

   assign branch_pc = branchTarget & AlignMask;

   // Next-state and IF/ID update; priority is branch > halt > hazard > normal fetch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      halt_pend_d  = halt_pend_q;
      buf_d        = buf_q;
      instr_d      = instr_q;
      pcout_d      = pcout_q;
      valid_d      = valid_q;
      load_live    = 1'b0;
      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (branchTaken) begin
               pc_d    = branch_pc;
               valid_d = 1'b0;
               if (!imemValid) begin
                  state_d      = StDrain;
                  drain_addr_d = pc_q;
               end
            end else if (haltSignal && valid_q) begin
               valid_d = 1'b0;
               if (imemValid) begin
                  state_d = StHalt;
               end else begin
                  state_d      = StDrain;
                  drain_addr_d = pc_q;
                  halt_pend_d  = 1'b1;
               end
            end else if (imemValid) begin
               pc_d = pc_q + PcStep;
               if (hazardDetected) begin
                  buf_d   = imemData;
                  state_d = StHold;
               end else begin
                  instr_d   = imemData;
                  pcout_d   = pc_q;
                  valid_d   = 1'b1;
                  load_live = 1'b1;
               end
            end else if (!hazardDetected) begin
               // Decode consumed the old word and nothing new arrived: insert a bubble.
               valid_d = 1'b0;
            end
         end
         StHold: begin
            if (branchTaken) begin
               pc_d    = branch_pc;
               valid_d = 1'b0;
               state_d = StFetch;
            end else if (haltSignal && valid_q) begin
               valid_d = 1'b0;
               state_d = StHalt;
            end else if (!hazardDetected) begin
               instr_d   = buf_q;
               pcout_d   = pc_q - PcStep;
               valid_d   = 1'b1;
               load_live = 1'b1;
               state_d   = StFetch;
            end
         end
         StDrain: begin
            if (branchTaken) begin
               pc_d        = branch_pc;
               valid_d     = 1'b0;
               halt_pend_d = 1'b0;
            end
            if (imemValid) begin
               halt_pend_d = 1'b0;
               state_d     = (halt_pend_q && !branchTaken) ? StHalt : StFetch;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and IF/ID registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         halt_pend_q  <= 1'b0;
         buf_q        <= '0;
         instr_q      <= '0;
         pcout_q      <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         halt_pend_q  <= halt_pend_d;
         buf_q        <= buf_d;
         instr_q      <= instr_d;
         pcout_q      <= pcout_d;
         valid_q      <= valid_d;
      end
   end

   assign imemReq     = (state_q == StFetch) || (state_q == StDrain);
   assign imemAddr    = (state_q == StDrain) ? drain_addr_q : pc_q;
   assign instruction = instr_q;
   assign pcOut       = pcout_q;
   assign instrValid  = valid_q;
   assign halted      = (state_q == StHalt);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (load_live && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (hazardDetected && valid_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign fetchCount = fetch_cnt_q;
   assign stallCount = stall_cnt_q;
`else
   logic unused_load_live;
   assign unused_load_live = load_live;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level model (next fetch address, optional
// stale request, optional held word) predicts every output each cycle under random and
// directed stimulus. Define FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        hazardDetected;
   logic        haltSignal;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemData;
   logic [31:0] instruction;
   logic [31:0] pcOut;
   logic        instrValid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetchCount;
   logic [31:0] stallCount;
`endif

   int checks = 0;
   int errors = 0;

   // Memory responder: a request is answered once it has waited lat cycles.
   int lat = 0;
   int wait_cnt = 0;
   bit force_valid = 1'b0;

   // Reference model
   bit          m_started, m_halted, m_discard, m_halt_after, m_buf_valid, m_iv;
   logic [31:0] m_pc, m_daddr, m_buf, m_bpc, m_instr, m_pcout;
   int unsigned m_fetch, m_stall;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .branchTaken   (branchTaken),
      .branchTarget  (branchTarget),
      .hazardDetected(hazardDetected),
      .haltSignal    (haltSignal),
      .imemReq       (imemReq),
      .imemAddr      (imemAddr),
      .imemValid     (imemValid),
      .imemData      (imemData),
      .instruction   (instruction),
      .pcOut         (pcOut),
      .instrValid    (instrValid),
`ifdef FETCH_PERF_CNT_EN
      .fetchCount    (fetchCount),
      .stallCount    (stallCount),
`endif
      .halted        (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a >> 2) + 32'd1) * 32'h11;
   endfunction

   task automatic model_reset();
      m_started = 0; m_halted = 0; m_discard = 0; m_halt_after = 0; m_buf_valid = 0;
      m_iv = 0; m_pc = 32'h0; m_daddr = 0; m_buf = 0; m_bpc = 0; m_instr = 0; m_pcout = 0;
      m_fetch = 0; m_stall = 0; wait_cnt = 0;
   endtask

   // One clock cycle: check the request side, drive inputs, advance model, check IF/ID side.
   task automatic run_cycle(input logic br, input logic [31:0] tgt, input logic hz,
                            input logic hs);
      logic        ereq, v, acc, iv_before;
      logic [31:0] eaddr, d;
      ereq  = m_started && !m_halted && !m_buf_valid;
      eaddr = m_discard ? m_daddr : m_pc;
      checks++;
      if (imemReq !== ereq) begin
         errors++;
         $display("FAIL imemReq: got %b expected %b at %0t", imemReq, ereq, $time);
      end
      if (ereq) begin
         checks++;
         if (imemAddr !== eaddr) begin
            errors++;
            $display("FAIL imemAddr: got %h expected %h at %0t", imemAddr, eaddr, $time);
         end
      end
      v = (ereq && (wait_cnt >= lat)) || force_valid;
      d = v ? mem_word(eaddr) : $urandom;
      branchTaken = br; branchTarget = tgt; hazardDetected = hz; haltSignal = hs;
      imemValid = v; imemData = d;
      @(posedge clk);
      iv_before = m_iv;
      acc = ereq && v;
      if (!m_started) begin
         m_started = 1;
      end else if (!m_halted) begin
         if (br) begin
            if (ereq && !acc) begin
               if (!m_discard) m_daddr = m_pc;
               m_discard = 1;
            end else begin
               m_discard = 0;
            end
            m_pc = tgt & 32'hFFFF_FFFC; m_iv = 0; m_buf_valid = 0; m_halt_after = 0;
         end else if (m_discard) begin
            if (acc) begin
               m_discard = 0;
               if (m_halt_after) begin m_halted = 1; m_halt_after = 0; end
            end
         end else if (hs && m_iv) begin
            m_iv = 0; m_buf_valid = 0;
            if (ereq && !acc) begin m_discard = 1; m_daddr = m_pc; m_halt_after = 1; end
            else m_halted = 1;
         end else if (m_buf_valid) begin
            if (!hz) begin
               m_instr = m_buf; m_pcout = m_bpc; m_iv = 1; m_buf_valid = 0; m_fetch++;
            end
         end else if (acc) begin
            if (hz) begin m_buf = d; m_bpc = m_pc; m_buf_valid = 1; end
            else begin m_instr = d; m_pcout = m_pc; m_iv = 1; m_fetch++; end
            m_pc = m_pc + 32'd4;
         end else if (!hz) begin
            m_iv = 0;
         end
      end
      if (hz && iv_before) m_stall++;
      if (ereq && !v) wait_cnt++; else wait_cnt = 0;
      @(negedge clk);
      checks += 4;
      if (instrValid !== m_iv) begin
         errors++;
         $display("FAIL instrValid: got %b expected %b at %0t", instrValid, m_iv, $time);
      end
      if (instruction !== m_instr) begin
         errors++;
         $display("FAIL instruction: got %h expected %h at %0t", instruction, m_instr, $time);
      end
      if (pcOut !== m_pcout) begin
         errors++;
         $display("FAIL pcOut: got %h expected %h at %0t", pcOut, m_pcout, $time);
      end
      if (halted !== m_halted) begin
         errors++;
         $display("FAIL halted: got %b expected %b at %0t", halted, m_halted, $time);
      end
`ifdef FETCH_PERF_CNT_EN
      checks += 2;
      if (fetchCount !== m_fetch) begin
         errors++;
         $display("FAIL fetchCount: got %0d expected %0d at %0t", fetchCount, m_fetch, $time);
      end
      if (stallCount !== m_stall) begin
         errors++;
         $display("FAIL stallCount: got %0d expected %0d at %0t", stallCount, m_stall, $time);
      end
`endif
   endtask

   // Pulse reset from a negedge, check the asynchronous reset values, release on next negedge.
   task automatic apply_reset();
      branchTaken = 0; hazardDetected = 0; haltSignal = 0; imemValid = 0; force_valid = 0;
      reset = 1'b0;
      #1;
      checks++;
      if (imemReq !== 1'b0 || instrValid !== 1'b0 || halted !== 1'b0 ||
          instruction !== 32'h0 || pcOut !== 32'h0) begin
         errors++;
         $display("FAIL reset_values: req=%b valid=%b halted=%b instr=%h pc=%h expected all 0",
                  imemReq, instrValid, halted, instruction, pcOut);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fetchCount !== 0 || stallCount !== 0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", fetchCount, stallCount);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_zero_wait();
      apply_reset();
      lat = 0;
      run_cycle(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0);
      checks++;
      if (instruction !== 32'h33 || pcOut !== 32'h8 || instrValid !== 1'b1) begin
         errors++;
         $display("FAIL zero_wait: got %h/%h/%b expected 00000033/00000008/1",
                  instruction, pcOut, instrValid);
      end
   endtask

   task automatic test_hazard();
      apply_reset();
      lat = 0;
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) run_cycle(0, 0, 1, 0);
      checks++;
      if (pcOut !== 32'h4 || instruction !== 32'h22) begin
         errors++;
         $display("FAIL hazard_freeze: got %h/%h expected 00000004/00000022", pcOut, instruction);
      end
      run_cycle(0, 0, 0, 0);
      checks++;
      if (pcOut !== 32'h8 || instruction !== 32'h33) begin
         errors++;
         $display("FAIL hazard_release: got %h/%h expected 00000008/00000033", pcOut, instruction);
      end
      run_cycle(0, 0, 0, 0);
      checks++;
      if (pcOut !== 32'hC || instruction !== 32'h44) begin
         errors++;
         $display("FAIL hazard_next: got %h/%h expected 0000000c/00000044", pcOut, instruction);
      end
   endtask

   task automatic test_branch_drain();
      apply_reset();
      lat = 0;
      run_cycle(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 0);
      lat = 2;
      run_cycle(0, 0, 0, 0);
      run_cycle(1, 32'h103, 0, 0);
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h10 || instrValid !== 1'b0) begin
         errors++;
         $display("FAIL branch_drain: got req=%b addr=%h valid=%b expected 1/00000010/0",
                  imemReq, imemAddr, instrValid);
      end
      run_cycle(0, 0, 0, 0);
      checks++;
      if (imemAddr !== 32'h100 || instrValid !== 1'b0) begin
         errors++;
         $display("FAIL branch_target: got addr=%h valid=%b expected 00000100/0",
                  imemAddr, instrValid);
      end
      for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 0);
   endtask

   task automatic test_halt();
      apply_reset();
      lat = 0;
      for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (halted !== 1'b1 || imemReq !== 1'b0) begin
            errors++;
            $display("FAIL halt: got halted=%b req=%b expected 1/0", halted, imemReq);
         end
         run_cycle(1, 32'h80, 0, 0);
      end
      apply_reset();
      for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0);
      run_cycle(1, 32'h40, 0, 1);
      checks++;
      if (halted !== 1'b0 || imemAddr !== 32'h40) begin
         errors++;
         $display("FAIL halt_vs_branch: got halted=%b addr=%h expected 0/00000040",
                  halted, imemAddr);
      end
      run_cycle(0, 0, 0, 0);
   endtask

   task automatic test_wrap();
      apply_reset();
      lat = 0;
      run_cycle(0, 0, 0, 0);
      run_cycle(1, 32'hFFFF_FFFF, 0, 0);
      run_cycle(0, 0, 0, 0);
      checks++;
      if (pcOut !== 32'hFFFF_FFFC || imemAddr !== 32'h0) begin
         errors++;
         $display("FAIL wrap: got pcOut=%h addr=%h expected fffffffc/00000000", pcOut, imemAddr);
      end
      run_cycle(0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_request();
      apply_reset();
      lat = 3;
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      apply_reset();
      lat = 0;
      force_valid = 1'b1;
      run_cycle(0, 0, 0, 0);
      force_valid = 1'b0;
      run_cycle(0, 0, 0, 0);
      checks++;
      if (pcOut !== 32'h0 || instruction !== 32'h11 || instrValid !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got %h/%h/%b expected 00000000/00000011/1",
                  pcOut, instruction, instrValid);
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf_counters();
      apply_reset();
      lat = 0;
      run_cycle(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 1, 0);
      run_cycle(0, 0, 1, 0);
      checks++;
      if (fetchCount !== 32'd5 || stallCount !== 32'd2) begin
         errors++;
         $display("FAIL perf: got %0d/%0d expected 5/2", fetchCount, stallCount);
      end
   endtask
`endif

   task automatic test_random();
      logic        br, hz, hs;
      logic [31:0] tgt;
      apply_reset();
      lat = $urandom_range(0, 3);
      for (int i = 0; i < 1500; i++) begin
         if (m_halted || $urandom_range(0, 99) == 0) begin
            apply_reset();
            lat = $urandom_range(0, 3);
         end
         br  = ($urandom_range(0, 11) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : ($urandom & 32'h0000_FFFF);
         hz  = ($urandom_range(0, 3) == 0);
         hs  = ($urandom_range(0, 29) == 0);
         run_cycle(br, tgt, hz, hs);
      end
   endtask

   initial begin
      reset = 1'b0;
      branchTaken = 0; branchTarget = 0; hazardDetected = 0; haltSignal = 0;
      imemValid = 0; imemData = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_hazard();
      test_branch_drain();
      test_halt();
      test_wrap();
      test_reset_mid_request();
`ifdef FETCH_PERF_CNT_EN
      test_perf_counters();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 32, giving the PC / instruction-memory address width.
REQ-002 SHALL have parameter DATA, default 32, giving the instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, giving the first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port branchTaken  input  1  redirect request from the downstream pipeline.
REQ-007 SHALL have port branchTarget  input  ADDRESSWIDTH  redirect address.
REQ-008 SHALL have port hazardDetected  input  1  decode-stage stall request.
REQ-009 SHALL have port haltSignal  input  1  decode flags the current IF/ID instruction as HALT.
REQ-010 SHALL have port imemReq  output  1  instruction-memory request.
REQ-011 SHALL have port imemAddr  output  ADDRESSWIDTH  request address.
REQ-012 SHALL have port imemValid  input  1  memory response valid.
REQ-013 SHALL have port imemData  input  DATA  memory response word.
REQ-014 SHALL have port instruction  output  DATA  IF/ID instruction register.
REQ-015 SHALL have port pcOut  output  ADDRESSWIDTH  IF/ID PC of instruction.
REQ-016 SHALL have port instrValid  output  1  IF/ID holds a live instruction.
REQ-017 SHALL have port halted  output  1  fetch permanently stopped.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN, HALT; imemReq=1 exactly in FETCH and DRAIN, and imemAddr=pc.
REQ-019 SHALL, once imemReq is high, hold imemReq and imemAddr stable until a cycle with imemValid=1; requests are never withdrawn.
REQ-020 SHALL accept imemValid in the same cycle imemReq rises (zero-wait memory gives one instruction per cycle).
REQ-021 SHALL move IDLE->FETCH unconditionally on the first clock edge after reset release.
REQ-022 SHALL, in FETCH with imemValid=1 and hazardDetected=0, load instruction=imemData, pcOut=pc, instrValid=1, pc<=pc+4, and stay in FETCH.
REQ-023 SHALL, in FETCH with imemValid=1 and hazardDetected=1, store imemData in a one-entry hold buffer, set pc<=pc+4, and go to HOLD; IF/ID is unchanged.
REQ-024 SHALL, in HOLD, keep IF/ID while hazardDetected=1; on the first cycle with hazardDetected=0, load IF/ID from the buffer (PC = pc-4) and go to FETCH.
REQ-025 SHALL keep instruction, pcOut and instrValid unchanged in every cycle hazardDetected=1, unless overridden by REQ-026/REQ-028.
REQ-026 SHALL, on branchTaken=1 in any state except IDLE/HALT: set pc<=branchTarget with bits [1:0] forced to 0, set instrValid<=0, and discard the hold buffer.
REQ-027 SHALL, when the branch of REQ-026 arrives in FETCH with imemValid=0, go to DRAIN, keep the old request until imemValid, discard that data, then enter FETCH at the new pc; if imemValid=1 in the branch cycle, discard the data and enter FETCH directly.
REQ-028 SHALL, on haltSignal=1 with instrValid=1 and branchTaken=0, go to HALT after any outstanding request completes (via DRAIN, data discarded), with instrValid=0 and halted=1; HALT exits only by reset.
REQ-029 SHALL apply priority reset > branchTaken > haltSignal > hazardDetected > normal fetch.
REQ-030 SHALL compute pc+4 modulo 2^ADDRESSWIDTH (0xFFFFFFFC+4 = 0x00000000).
REQ-031 SHALL ignore imemValid in IDLE, HOLD and HALT.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=IDLE, pc=RESET_PC, imemReq=0, instruction=0, pcOut=0, instrValid=0, halted=0, hold buffer empty, and counters 0.
REQ-033 SHALL treat reset mid-request as aborting it; a late imemValid after reset is ignored by the IDLE state.

Configuration
REQ-034 SHALL, when macro FETCH_PERF_CNT_EN is defined, add 32-bit outputs fetchCount (+1 per IF/ID load of a live instruction) and stallCount (+1 per cycle with hazardDetected=1 and instrValid=1), both saturating at 0xFFFFFFFF.
REQ-035 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters; all other behaviour is identical.

Verification
REQ-036 Reset release, zero-wait memory returning 0x11,0x22,0x33 -> imemAddr 0x0,0x4,0x8 on consecutive cycles; pcOut/instruction 0x0/0x11, 0x4/0x22, 0x8/0x33, one cycle after each response.
REQ-037 hazardDetected=1 for 3 cycles while IF/ID holds pc 0x4 -> IF/ID frozen 3 cycles; next word (0x8) buffered; it appears the cycle after the hazard clears; no word is lost or duplicated.
REQ-038 3-cycle-latency memory, branchTaken with branchTarget 0x103 one cycle after request 0x10 -> DRAIN holds 0x10 until imemValid, data dropped, instrValid=0, next imemAddr=0x100.
REQ-039 haltSignal=1 with instrValid=1 -> halted=1, imemReq=0 thereafter; branchTaken in the same cycle -> fetch at target instead, halted=0.
REQ-040 pc=0xFFFFFFFC fetch -> next imemAddr 0x00000000; with FETCH_PERF_CNT_EN, 5 fetches plus 2 stall cycles -> fetchCount=5, stallCount=2.
